// File: rtl/trig_arb_if.sv
// Request/response/evaluator bundle for the two-channel sin/cos arbiter.
// slave = arbiter side, master = requester/consumer/evaluator side.
interface trig_arb_if;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_u1, req1_u1;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp0_g0, rsp0_g1, rsp1_g0, rsp1_g1;
  logic [1:0]  rsp0_quad, rsp1_quad;
  logic [15:0] trig_u1;
  logic [15:0] trig_g0, trig_g1;
  logic [1:0]  trig_quad;

  modport slave (
    input  req0_valid, req1_valid, req0_u1, req1_u1, rsp0_ready, rsp1_ready,
           trig_g0, trig_g1, trig_quad,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_g0, rsp0_g1, rsp1_g0, rsp1_g1, rsp0_quad, rsp1_quad, trig_u1
  );

  modport master (
    output req0_valid, req1_valid, req0_u1, req1_u1, rsp0_ready, rsp1_ready,
           trig_g0, trig_g1, trig_quad,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_g0, rsp0_g1, rsp1_g0, rsp1_g1, rsp0_quad, rsp1_quad, trig_u1
  );
endinterface

// File: rtl/trig_arb.sv
// Two-channel round-robin front end for one shared sin/cos evaluator; result valid LAT+1 clocks after accept.
// Backpressure: a full result buffer blocks only its own channel. TRIG_ARB_QUAD_FOLD_EN swaps g0/g1 when quad[0]=1.
module trig_arb #(
  parameter int LAT = 1
) (
  input logic     clk,
  input logic     rst_n,
  trig_arb_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] op_q;
  logic        owner_q;
  logic        last_q;
  logic [1:0]  vld_q;
  logic [15:0] g0_q [2];
  logic [15:0] g1_q [2];
  logic [1:0]  quad_q [2];

  logic        elig0, elig1, gnt0, gnt1;
  logic [1:0]  pop;
  logic [15:0] cap_g0_d, cap_g1_d;

  assign elig0 = bus.req0_valid & ~vld_q[0];
  assign elig1 = bus.req1_valid & ~vld_q[1];
  // On a tie the channel that did not win last time goes first.
  assign gnt0  = rst_n && (state_q == IDLE) && elig0 && (!elig1 || last_q);
  assign gnt1  = rst_n && (state_q == IDLE) && elig1 && (!elig0 || !last_q);
  assign pop   = vld_q & {bus.rsp1_ready, bus.rsp0_ready};

`ifdef TRIG_ARB_QUAD_FOLD_EN
  assign cap_g0_d = bus.trig_quad[0] ? bus.trig_g1 : bus.trig_g0;
  assign cap_g1_d = bus.trig_quad[0] ? bus.trig_g0 : bus.trig_g1;
`else
  assign cap_g0_d = bus.trig_g0;
  assign cap_g1_d = bus.trig_g1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      vld_q     <= '0;
      g0_q[0]   <= '0;
      g0_q[1]   <= '0;
      g1_q[0]   <= '0;
      g1_q[1]   <= '0;
      quad_q[0] <= '0;
      quad_q[1] <= '0;
    end else begin
      // Pop first so a capture for the other channel on the same edge still lands.
      vld_q <= vld_q & ~pop;
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_q    <= gnt1 ? bus.req1_u1 : bus.req0_u1;
            owner_q <= gnt1;
            last_q  <= gnt1;
            cnt_q   <= 3'(LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            vld_q[owner_q]  <= 1'b1;
            g0_q[owner_q]   <= cap_g0_d;
            g1_q[owner_q]   <= cap_g1_d;
            quad_q[owner_q] <= bus.trig_quad;
            state_q         <= IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.trig_u1    = op_q;
  assign bus.rsp0_valid = vld_q[0];
  assign bus.rsp1_valid = vld_q[1];
  assign bus.rsp0_g0    = g0_q[0];
  assign bus.rsp0_g1    = g1_q[0];
  assign bus.rsp1_g0    = g0_q[1];
  assign bus.rsp1_g1    = g1_q[1];
  assign bus.rsp0_quad  = quad_q[0];
  assign bus.rsp1_quad  = quad_q[1];

endmodule
